// File: rtl/gate_tt_checker.sv
// Clocked truth-table sweep for a 2-input NAND: drives A/B, samples Y, counts mismatches.
// Optional macro GATE_TT_CHECK_STOP_ON_FAIL_EN ends the run at the first mismatching sample.
module gate_tt_checker #(
  parameter int HOLD_CYCLES = 2,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic             fail_valid
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ab_q, ab_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             fvalid_q, fvalid_d;
  logic             mismatch;
  logic             stop_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ab_q     <= 2'b00;
      hold_q   <= '0;
      pcnt_q   <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      fvec_q   <= 2'b00;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ab_q     <= ab_d;
      hold_q   <= hold_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ab_d     = ab_q;
    hold_d   = hold_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
    mismatch = (Y != ~(ab_q[1] & ab_q[0]));
    stop_run = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HOLD;
          ab_d     = 2'b00;
          hold_d   = '0;
          pcnt_d   = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fvec_d   = 2'b00;
          fvalid_d = 1'b0;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fvalid_q) begin
            fvec_d   = ab_q;
            fvalid_d = 1'b1;
          end
        end
        stop_run = (ab_q == 2'b11) && (pcnt_q == PASS_LAST);
`ifdef GATE_TT_CHECK_STOP_ON_FAIL_EN
        stop_run = stop_run | mismatch;
`endif
        if (stop_run) begin
          // Verdict must reflect the count including this final sample.
          state_d = S_DONE;
          ab_d    = 2'b00;
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_HOLD;
          ab_d    = ab_q + 2'b01;
          hold_d  = '0;
          if (ab_q == 2'b11) pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign A          = ab_q[1];
  assign B          = ab_q[0];
  assign busy       = (state_q == S_HOLD) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: runs push expected verdicts, a done-monitor pops and compares.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: defaults; dut8: PASSES=8
  logic start0, a0, b0, y0, busy0, done0, pass0, fval0;
  logic [3:0] err0;
  logic [1:0] fv0;
  logic start8, a8, b8, y8, busy8, done8, pass8, fval8;
  logic [3:0] err8;
  logic [1:0] fv8;

  int mode0, mode8;  // 0 NAND, 1 stuck-1, 2 AND, 3 stuck-0

  function automatic logic gate_model(int mode, logic a, logic b);
    case (mode)
      0:       return ~(a & b);
      1:       return 1'b1;
      2:       return a & b;
      default: return 1'b0;
    endcase
  endfunction

  assign y0 = gate_model(mode0, a0, b0);
  assign y8 = gate_model(mode8, a8, b8);

  gate_tt_checker #(.HOLD_CYCLES(2), .PASSES(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .Y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fv0), .fail_valid(fval0)
  );

  gate_tt_checker #(.HOLD_CYCLES(2), .PASSES(8), .ERR_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Y(y8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .fail_vec(fv8), .fail_valid(fval8)
  );

  typedef struct {
    int         c0;
    int         lat;
    logic [3:0] err;
    logic       pass;
    logic [1:0] fv;
    logic       fval;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(string who, int is8);
    exp_t e;
    if ((is8 != 0 && q8.size() == 0) || (is8 == 0 && q0.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_done: got done=1 expected done=0 (cycle %0d)", who, cyc);
    end else begin
      e = (is8 != 0) ? q8.pop_front() : q0.pop_front();
      if (is8 != 0) begin
        check({who, "_latency"}, cyc - e.c0, e.lat);
        check({who, "_err_count"}, int'(err8), int'(e.err));
        check({who, "_pass"}, int'(pass8), int'(e.pass));
        check({who, "_fail_vec"}, int'(fv8), int'(e.fv));
        check({who, "_fail_valid"}, int'(fval8), int'(e.fval));
        $display("run %s: lat=%0d err=%0d pass=%0b fail_vec=%b fail_valid=%0b",
                 who, cyc - e.c0, err8, pass8, fv8, fval8);
      end else begin
        check({who, "_latency"}, cyc - e.c0, e.lat);
        check({who, "_err_count"}, int'(err0), int'(e.err));
        check({who, "_pass"}, int'(pass0), int'(e.pass));
        check({who, "_fail_vec"}, int'(fv0), int'(e.fv));
        check({who, "_fail_valid"}, int'(fval0), int'(e.fval));
        $display("run %s: lat=%0d err=%0d pass=%0b fail_vec=%b fail_valid=%0b",
                 who, cyc - e.c0, err0, pass0, fv0, fval0);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, fires on every done pulse
  always @(negedge clk) begin
    if (done0) score("dut0", 0);
    if (done8) score("dut8", 1);
  end

  function automatic exp_t mk(int c0, int lat, int err, logic p, logic [1:0] fv, logic fval);
    exp_t e;
    e.c0 = c0; e.lat = lat; e.err = 4'(err); e.pass = p; e.fv = fv; e.fval = fval;
    return e;
  endfunction

  // Returns at the negedge after the accepting edge e0; c0 = cycle number of e0
  task automatic launch0(int mode, int lat, int err, logic p, logic [1:0] fv, logic fval,
                         bit push, output int c0);
    @(negedge clk);
    mode0 = mode;
    start0 = 1'b1;
    c0 = cyc + 1;
    if (push) q0.push_back(mk(c0, lat, err, p, fv, fval));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((q0.size() != 0 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q0.size() != 0 || q8.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d pending runs expected 0", q0.size() + q8.size());
      q0.delete();
      q8.delete();
    end
  endtask

  initial begin
    int c0;
    int lat_stop;
    rst = 1'b1;
    start0 = 1'b0;
    start8 = 1'b0;
    mode0 = 0;
    mode8 = 0;
    #1;
    check("reset_ab", int'({a0, b0}), 0);
    check("reset_busy_done", int'({busy0, done0, busy8, done8}), 0);
    check("reset_pass_err", int'({pass0, err0}), 0);
    check("reset_fail", int'({fv0, fval0}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct NAND: step through vectors every 3 cycles, busy until DONE
    launch0(0, 12, 0, 1'b1, 2'b00, 1'b0, 1'b1, c0);
    for (int k = 0; k <= 12; k++) begin
      check($sformatf("t1_ab_k%0d", k), int'({a0, b0}), (k < 12) ? (k / 3) : 0);
      check($sformatf("t1_busy_k%0d", k), int'(busy0), (k < 12) ? 1 : 0);
      @(negedge clk);
    end
    wait_drain(50);

    // Stuck-at-1: only vector 11 fails
    launch0(1, 12, 1, 1'b0, 2'b11, 1'b1, 1'b1, c0);
    wait_drain(50);
    repeat (3) @(negedge clk);
    check("t2_held_err", int'(err0), 1);
    check("t2_held_fail", int'({fv0, fval0}), 7);
    check("t2_held_busy", int'(busy0), 0);

    // Stuck-at-0: vectors 00,01,10 fail
`ifdef GATE_TT_CHECK_STOP_ON_FAIL_EN
    lat_stop = 3;
    launch0(3, 3, 1, 1'b0, 2'b00, 1'b1, 1'b1, c0);
`else
    lat_stop = 12;
    launch0(3, 12, 3, 1'b0, 2'b00, 1'b1, 1'b1, c0);
`endif
    wait_drain(50);
    check("t3_lat_param", lat_stop > 0 ? int'(busy0) : 1, 0);

    // Wrong gate (AND), 8 passes: 32 mismatches saturate at 15
    @(negedge clk);
    mode8 = 2;
    start8 = 1'b1;
    c0 = cyc + 1;
`ifdef GATE_TT_CHECK_STOP_ON_FAIL_EN
    q8.push_back(mk(c0, 3, 1, 1'b0, 2'b00, 1'b1));
`else
    q8.push_back(mk(c0, 96, 15, 1'b0, 2'b00, 1'b1));
`endif
    @(negedge clk);
    start8 = 1'b0;
    wait_drain(200);

    // Reset after the vector-2 sample aborts the run with no done pulse
    launch0(0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, c0);
    repeat (9) @(negedge clk);
    check("t5_pre_rst_ab", int'({a0, b0}), 3);
    rst = 1'b1;
    #1;
    check("t5_rst_ab_busy", int'({a0, b0, busy0, done0}), 0);
    check("t5_rst_verdict", int'({pass0, err0, fv0, fval0}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_idle_after_rst", int'(busy0), 0);
    launch0(0, 12, 0, 1'b1, 2'b00, 1'b0, 1'b1, c0);
    wait_drain(50);

    // start held high: one run per IDLE visit, second accepted two edges after the last sample
    @(negedge clk);
    mode0 = 0;
    start0 = 1'b1;
    c0 = cyc + 1;
    q0.push_back(mk(c0, 12, 0, 1'b1, 2'b00, 1'b0));
    q0.push_back(mk(c0 + 14, 12, 0, 1'b1, 2'b00, 1'b0));
    repeat (14) @(negedge clk);
    check("t6_idle_pass_held", int'(pass0), 1);
    check("t6_idle_not_busy", int'(busy0), 0);
    @(negedge clk);
    check("t6_pass_cleared", int'(pass0), 0);
    check("t6_rerun_busy", int'(busy0), 1);
    start0 = 1'b0;
    wait_drain(50);
    repeat (4) @(negedge clk);
    check("t6_no_third_run", int'(busy0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
